cascade_mod_counter: RTL
========================

Name: cascade_mod_counter

Overview:
Parametrised multi-digit cascaded modulo counter with a per-digit modulus, up/down direction, synchronous parallel load and a registered carry/borrow chain. It generalises the team's single-digit mod-6 counter with carry. The default configuration is a 0..59 seconds counter: digit0 is mod 10, digit1 is mod 6. It serves as the timebase building block for clock/timer datapaths and cascades into further instances through co.

Parameters:
NUM_DIGITS, 2, number of cascaded digits (1..8).
DIGIT_W, 4, bits per digit (2..8).
MOD_LIST, {4'd6,4'd10}, packed moduli NUM_DIGITS*DIGIT_W bits; digit i modulus at [i*DIGIT_W +: DIGIT_W]; field value 0 means 2^DIGIT_W; field value 1 is illegal.

Ports:
clk  input  1  clock, all state updates on posedge.
rst  input  1  reset, synchronous, active-high.
en  input  1  count enable; acts as carry-in to digit0.
up  input  1  direction: 1 = increment, 0 = decrement.
load  input  1  synchronous parallel load strobe.
load_val  input  NUM_DIGITS*DIGIT_W  packed load value, same layout as count.
count  output  NUM_DIGITS*DIGIT_W  packed digit values, registered.
digit_co  output  NUM_DIGITS  per-digit wrap pulse, registered.
co  output  1  whole-chain carry/borrow pulse, registered.

Behaviour:
- Reset: while rst=1 at posedge, all digits in count <= 0, digit_co <= 0, co <= 0.
- Priority at each posedge: rst > load > en. up is sampled only when en=1.
- Load (load=1, rst=0): each digit <= its load_val field. A field >= its digit modulus loads 0 for that digit. digit_co <= 0, co <= 0. en is ignored in that cycle.
- Terminal value: MAX_i = MOD_i-1 when counting up; 0 when counting down.
- Digit i steps when en=1 and every digit j<i is at its terminal value; this is combinational, so the whole chain updates in the same cycle.
- Up step: digit == MOD_i-1 wraps to 0; otherwise it increments by 1.
- Down step: digit == 0 wraps to MOD_i-1; otherwise it decrements by 1.
- digit_co[i] <= 1 in exactly the cycle digit i wraps; otherwise 0.
- co <= 1 when en=1 and all digits are at their terminal value, i.e. the whole chain wraps. Otherwise co <= 0.
- co is a single-cycle pulse, including when en=0: en low holds count and clears co and digit_co. This differs from the older mod-6 counter, where co held its value while en was low.
- Latency: count, digit_co and co all reflect an en edge one cycle after the sampling posedge. The carry ripple adds no extra cycles.
- Direction change mid-count takes effect on the next enabled edge. There are no invalid intermediate values.
- Reset mid-operation overrides load and en in the same cycle.
- Digit values never exceed MOD_i-1 under any input sequence.
- Arithmetic is per-digit DIGIT_W-bit with explicit compare-and-wrap. There is no binary overflow between fields.

Optional Feature:
Macro CASCADE_MOD_COUNTER_OVF_STICKY_EN.
- Defined:
  - Adds output ovf_sticky (1 bit) and input ovf_clr (1 bit).
  - ovf_sticky <= 1 on any cycle co is set to 1.
  - ovf_sticky is cleared by rst, or by ovf_clr=1. ovf_clr takes priority over a same-cycle set: it clears, and the set is lost.
  - load does not affect ovf_sticky.
- Not defined: neither port exists and no extra flop is instantiated. All other behaviour is identical.

Test Plan:
- Reset, then en=1, up=1 for 59 cycles -> count digit1=5, digit0=9, co=0. One more cycle -> count=00, co=1 for exactly one cycle, digit_co=2'b11.
- Count up to 09, next enabled edge -> count=10, digit_co=2'b01, co=0.
- From 00 with up=0, en=1, one edge -> count=59, co=1, digit_co=2'b11. Next edge -> 58, co=0.
- load=1, load_val={4'd3,4'd7}, en=1 simultaneously -> count=37 (en ignored). load_val={4'd7,4'd12} -> count=00 (both fields out of range).
- At count=59 with en=1, up=1, drop en for 3 cycles -> co pulses once then holds 0, count holds 00. Assert rst with en=1 and load=1 -> count=00, co=0.
- With CASCADE_MOD_COUNTER_OVF_STICKY_EN: wrap 59->00 -> ovf_sticky=1, and it stays 1 after 10 more counts. ovf_clr=1 in the same cycle as the next wrap -> ovf_sticky=0.

Source files
------------

// File: rtl/cascade_mod_counter.sv
// cascade_mod_counter: cascaded per-digit modulo up/down counter with load and registered carry chain.
// Define CASCADE_MOD_COUNTER_OVF_STICKY_EN to add the ovf_sticky flag and its ovf_clr input.
module cascade_mod_counter #(
    parameter int NUM_DIGITS = 2,
    parameter int DIGIT_W = 4,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] MOD_LIST = {4'd6, 4'd10}
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          up,
    input  logic                          load,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] load_val,
    output logic [NUM_DIGITS*DIGIT_W-1:0] count,
    output logic [NUM_DIGITS-1:0]         digit_co,
`ifdef CASCADE_MOD_COUNTER_OVF_STICKY_EN
    output logic                          co,
    input  logic                          ovf_clr,
    output logic                          ovf_sticky
`else
    output logic                          co
`endif
);
    logic [NUM_DIGITS*DIGIT_W-1:0] count_q, count_d;
    logic [NUM_DIGITS-1:0]         dco_q, dco_d, term;
    logic [NUM_DIGITS:0]           chain;
    logic                          co_q, co_d;

    // chain[i] is the step enable of digit i; chain[i+1] doubles as its wrap flag
    assign chain[0] = en;

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
            // a modulus field of 0 yields an all-ones max, i.e. modulus 2^DIGIT_W
            logic [DIGIT_W-1:0] mx, cur, ld, nxt;
            assign mx  = MOD_LIST[g*DIGIT_W +: DIGIT_W] - DIGIT_W'(1);
            assign cur = count_q[g*DIGIT_W +: DIGIT_W];
            assign ld  = load_val[g*DIGIT_W +: DIGIT_W];
            assign term[g] = cur == (up ? mx : '0);
            assign chain[g+1] = chain[g] & term[g];
            assign nxt = !chain[g] ? cur :
                         term[g]   ? (up ? '0 : mx) :
                         up        ? cur + DIGIT_W'(1) : cur - DIGIT_W'(1);
            assign count_d[g*DIGIT_W +: DIGIT_W] = load ? (ld > mx ? '0 : ld) : nxt;
        end
    endgenerate

    assign dco_d = load ? '0 : chain[NUM_DIGITS:1];
    assign co_d  = !load & chain[NUM_DIGITS];

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            dco_q   <= '0;
            co_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            dco_q   <= dco_d;
            co_q    <= co_d;
        end
    end

`ifdef CASCADE_MOD_COUNTER_OVF_STICKY_EN
    logic ovf_q;
    always_ff @(posedge clk) begin
        if (rst || ovf_clr)
            ovf_q <= 1'b0;
        else if (co_d)
            ovf_q <= 1'b1;
    end
    assign ovf_sticky = ovf_q;
`endif

    assign count    = count_q;
    assign digit_co = dco_q;
    assign co       = co_q;
endmodule
